// File: rtl/vector_normalize.sv
// vector_normalize: divides each of four unsigned lanes by a supplied L2 norm,
// producing Q1.FRAC unit-vector lanes with one restoring-division step per cycle.
// Optional feature: define VECTOR_NORMALIZE_ROUND_EN to compute one guard bit per
// lane and round half up instead of truncating.
module vector_normalize #(
    parameter int WIDTH      = 4,
    parameter int NORM_WIDTH = WIDTH + 2,
    parameter int FRAC       = WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [4*WIDTH-1:0]        V_in,
    input  logic [NORM_WIDTH-1:0]     norm_in,
    output logic [4*(FRAC+1)-1:0]     U_out,
    output logic                      busy,
    output logic                      done,
    output logic                      div_zero
);

`ifdef VECTOR_NORMALIZE_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    localparam int Q  = WIDTH + FRAC;
    localparam int QS = Q + GUARD;
    localparam int CW = $clog2(QS + 1);
    localparam int RW = NORM_WIDTH + 1;
    localparam int LW = FRAC + 1;
    localparam logic [Q:0] SAT_FULL = {{Q{1'b0}}, 1'b1} << FRAC;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        FINISH
    } state_t;

    state_t                  state;
    logic [1:0]              idx;
    logic [CW-1:0]           step;
    logic [4*WIDTH-1:0]      v_lat;
    logic [NORM_WIDTH-1:0]   norm_lat;
    logic [QS-1:0]           dividend;
    logic [RW-1:0]           rem;
    logic [QS-1:0]           quo;
    logic [LW-1:0]           results [4];

    logic [RW-1:0]           rem_shift;
    logic [RW-1:0]           norm_ext;
    logic [RW-1:0]           rem_next;
    logic [QS-1:0]           quo_next;
    logic [Q:0]              lane_full;
    logic [LW-1:0]           lane_res;
    logic [WIDTH-1:0]        cur_lane;

    // One restoring-division step plus the saturated lane result it would produce
    always_comb begin
        cur_lane  = v_lat[int'(idx)*WIDTH +: WIDTH];
        rem_shift = {rem[RW-2:0], dividend[QS-1]};
        norm_ext  = {1'b0, norm_lat};
        rem_next  = rem_shift;
        quo_next  = {quo[QS-2:0], 1'b0};
        if (rem_shift >= norm_ext) begin
            rem_next = rem_shift - norm_ext;
            quo_next = {quo[QS-2:0], 1'b1};
        end
`ifdef VECTOR_NORMALIZE_ROUND_EN
        lane_full = {1'b0, quo_next[QS-1:1]} + {{Q{1'b0}}, quo_next[0]};
`else
        lane_full = {1'b0, quo_next};
`endif
        lane_res = (lane_full > SAT_FULL) ? SAT_FULL[LW-1:0] : lane_full[LW-1:0];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            step     <= '0;
            v_lat    <= '0;
            norm_lat <= '0;
            dividend <= '0;
            rem      <= '0;
            quo      <= '0;
            for (int k = 0; k < 4; k++) results[k] <= '0;
            U_out    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        v_lat    <= V_in;
                        norm_lat <= norm_in;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (norm_lat == '0) begin
                        state <= FINISH;
                    end else begin
                        dividend <= {cur_lane, {(FRAC + GUARD){1'b0}}};
                        rem      <= '0;
                        quo      <= '0;
                        step     <= '0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    rem      <= rem_next;
                    quo      <= quo_next;
                    dividend <= {dividend[QS-2:0], 1'b0};
                    step     <= step + 1'b1;
                    if (step == CW'(QS - 1)) begin
                        results[idx] <= lane_res;
                        if (idx == 2'd3) begin
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                FINISH: begin
                    for (int k = 0; k < 4; k++) begin
                        U_out[k*LW +: LW] <= (norm_lat == '0) ? '0 : results[k];
                    end
                    div_zero <= (norm_lat == '0);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_normalize.sv
// Directed self-checking bench for vector_normalize at default parameters.
// Expected values track VECTOR_NORMALIZE_ROUND_EN when the bench is built with it.
module tb_vector_normalize;

    localparam int W  = 4;
    localparam int NW = 6;
    localparam int F  = 4;
    localparam int LW = F + 1;

`ifdef VECTOR_NORMALIZE_ROUND_EN
    localparam int LAT = 41;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 37;
    localparam bit RND = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [4*W-1:0]    V_in;
    logic [NW-1:0]     norm_in;
    logic [4*LW-1:0]   U_out;
    logic              busy;
    logic              done;
    logic              div_zero;

    int compared;
    int mismatched;

    vector_normalize dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .V_in     (V_in),
        .norm_in  (norm_in),
        .U_out    (U_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] pack_v(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [4*LW-1:0] pack_u(input int a, input int b, input int c, input int d);
        return {LW'(d), LW'(c), LW'(b), LW'(a)};
    endfunction

    // Issue one request and wait (bounded) for done; reports latency and busy behaviour
    task automatic run_op(input logic [4*W-1:0] v, input logic [NW-1:0] n,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        V_in    = v;
        norm_in = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        V_in = '0;
        norm_in = '0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({U_out, busy, done, div_zero} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got U_out=%h busy=%b done=%b dz=%b, want all 0",
                     U_out, busy, done, div_zero);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        logic [4*LW-1:0] exp_u;
        exp_u = RND ? pack_u(10, 13, 0, 0) : pack_u(9, 12, 0, 0);
        run_op(pack_v(3, 4, 0, 0), 6'd5, lat, bok);
        compared++;
        if (lat !== LAT) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d, want %0d", lat, LAT);
        end
        compared++;
        if (U_out !== exp_u) begin
            mismatched++;
            $display("[TB] FAIL basic_result: got %h, want %h", U_out, exp_u);
        end
        compared++;
        if (div_zero !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_div_zero: got %b, want 0", div_zero);
        end
        compared++;
        if (bok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_busy: got busy_ok=%b, want 1", bok);
        end
        // Outputs must hold and done must stay low while idle
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (U_out !== exp_u || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_between_done: got U_out=%h done=%b, want %h / 0", U_out, done, exp_u);
        end
    endtask

    task automatic test_equal_lanes();
        int lat;
        bit bok;
        run_op(pack_v(15, 15, 15, 15), 6'd30, lat, bok);
        compared++;
        if (U_out !== pack_u(8, 8, 8, 8) || lat !== LAT) begin
            mismatched++;
            $display("[TB] FAIL equal_lanes: got U_out=%h lat=%0d, want %h lat=%0d",
                     U_out, lat, pack_u(8, 8, 8, 8), LAT);
        end
    endtask

    task automatic test_saturate();
        int lat;
        bit bok;
        run_op(pack_v(15, 0, 1, 0), 6'd1, lat, bok);
        compared++;
        if (U_out !== pack_u(16, 0, 16, 0)) begin
            mismatched++;
            $display("[TB] FAIL saturate: got %h, want %h", U_out, pack_u(16, 0, 16, 0));
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int extra;
        bit bok;
        logic [4*LW-1:0] exp_u;
        exp_u = RND ? pack_u(10, 13, 0, 0) : pack_u(9, 12, 0, 0);
        @(negedge clk);
        V_in    = pack_v(3, 4, 0, 0);
        norm_in = 6'd5;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = -1;
        bok     = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 10) begin
                V_in    = pack_v(15, 15, 15, 15);
                norm_in = 6'd30;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) bok = 1'b0;
        end
        start = 1'b0;
        compared++;
        if (lat !== LAT || U_out !== exp_u) begin
            mismatched++;
            $display("[TB] FAIL ignore_start_busy: got lat=%0d U_out=%h, want lat=%0d U_out=%h",
                     lat, U_out, LAT, exp_u);
        end
        compared++;
        if (bok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_throughout: got busy_ok=%b, want 1", bok);
        end
        extra = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL single_done: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_zero_norm();
        int lat;
        bit bok;
        run_op(pack_v(7, 2, 9, 1), 6'd0, lat, bok);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("[TB] FAIL zero_latency: got %0d, want 2", lat);
        end
        compared++;
        if (U_out !== '0 || div_zero !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_result: got U_out=%h dz=%b, want 0 / 1", U_out, div_zero);
        end
        run_op(pack_v(15, 15, 15, 15), 6'd30, lat, bok);
        compared++;
        if (div_zero !== 1'b0 || U_out !== pack_u(8, 8, 8, 8)) begin
            mismatched++;
            $display("[TB] FAIL zero_then_valid: got dz=%b U_out=%h, want 0 / %h",
                     div_zero, U_out, pack_u(8, 8, 8, 8));
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        bit bok;
        @(negedge clk);
        V_in    = pack_v(3, 4, 0, 0);
        norm_in = 6'd5;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        compared++;
        if (U_out !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_clear: got U_out=%h busy=%b done=%b dz=%b, want all 0",
                     U_out, busy, done, div_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles, want 0", seen);
        end
        run_op(pack_v(15, 0, 1, 0), 6'd1, lat, bok);
        compared++;
        if (lat !== LAT || U_out !== pack_u(16, 0, 16, 0)) begin
            mismatched++;
            $display("[TB] FAIL after_abort: got lat=%0d U_out=%h, want lat=%0d U_out=%h",
                     lat, U_out, LAT, pack_u(16, 0, 16, 0));
        end
    endtask

    // Scenario sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_equal_lanes();
        test_saturate();
        test_back_to_back();
        test_zero_norm();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vector_normalize.md
VECTOR_NORMALIZE -- requirements
Module: vector_normalize

Interface
REQ-001 Parameter WIDTH, default 4, unsigned bit width of each input vector lane.
REQ-002 Parameter NORM_WIDTH, default WIDTH+2, bit width of the norm input.
REQ-003 Parameter FRAC, default WIDTH, fractional bits of each output lane.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-006 start  input  1  request to normalize; sampled only in IDLE.
REQ-007 V_in  input  4*WIDTH  four unsigned lanes; lane k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-008 norm_in  input  NORM_WIDTH  unsigned L2 norm of V_in, as produced by the team's norm block.
REQ-009 U_out  output  4*(FRAC+1)  four unsigned Q1.FRAC lanes; lane k at bits [(k+1)*(FRAC+1)-1 : k*(FRAC+1)].
REQ-010 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-011 done  output  1  one-cycle pulse marking U_out and div_zero valid.
REQ-012 div_zero  output  1  high when the last accepted request had norm_in == 0.

Function
REQ-013 States SHALL be IDLE, LOAD, DIV, FINISH; the encoding is free.
REQ-014 IDLE with start=1: latch V_in and norm_in, clear lane index, and go to LOAD; if latched norm is 0, go to FINISH instead.
REQ-015 LOAD: dividend = lane[idx] << FRAC (WIDTH+FRAC bits); clear partial remainder and quotient; go to DIV.
REQ-016 DIV: one restoring-division step per cycle, MSB first, for Q = WIDTH+FRAC cycles; remainder register NORM_WIDTH+1 bits wide, so there is no overflow.
REQ-017 After the last DIV step, store the lane result; if idx==3 go to FINISH, else increment idx and go to LOAD.
REQ-018 Lane result = floor(lane*2^FRAC / norm), saturated to 2^FRAC (Q1.FRAC value 1.0) if larger.
REQ-019 FINISH: load all four results into U_out simultaneously, pulse done for one cycle, return to IDLE.
REQ-020 Latency from the start-sampling edge to the done-high cycle SHALL be 4*(Q+1)+1 cycles (37 at defaults).
REQ-021 norm_in == 0: U_out = all zeros, div_zero=1, done high 2 cycles after the start edge; no division performed.
REQ-022 div_zero SHALL update only with done and hold until the next done.
REQ-023 start while busy SHALL be ignored; the latched inputs are unaffected by V_in/norm_in changes mid-operation.
REQ-024 start high in the FINISH cycle SHALL be ignored; it is accepted only in the following IDLE cycle.
REQ-025 U_out SHALL hold its value between done pulses.

Reset
REQ-026 While reset=0: state=IDLE; U_out=0; busy=0; done=0; div_zero=0; all internal registers are 0.
REQ-027 Reset asserted mid-operation SHALL abort the request with no done pulse; the first start after release begins a fresh operation.

Configuration
REQ-028 Macro VECTOR_NORMALIZE_ROUND_EN defined: one extra DIV step per lane (Q+1 steps) produces a guard bit; the lane result is the truncated quotient plus the guard bit (round half up), then saturated per REQ-018; latency = 4*(Q+2)+1 (41 at defaults).
REQ-029 Macro undefined: truncation per REQ-018 and latency per REQ-020; no rounding logic is present.

Verification (defaults WIDTH=4, FRAC=4)
REQ-030 V_in lanes (3,4,0,0), norm_in=5, start -> done at cycle 37, U_out lanes (9,12,0,0), div_zero=0; with ROUND_EN: cycle 41, (10,13,0,0).
REQ-031 Lanes (15,15,15,15), norm_in=30, start -> U_out lanes all 8, div_zero=0.
REQ-032 norm_in=0, any V_in, start -> done 2 cycles later, U_out=0, div_zero=1; next valid request clears div_zero at its done.
REQ-033 Lanes (15,0,1,0), norm_in=1 -> lane0=16 (saturated), lane1=0, lane2=16, lane3=0.
REQ-034 start pulsed again at cycle 10 with different V_in -> exactly one done, with results of the first request; busy stays high throughout.
REQ-035 reset driven low at cycle 20 of an operation -> outputs 0 immediately, no done; a new start after release gives correct results at full latency.
